// File: rtl/four_connect_pkg.sv
// four_connect_pkg: shared codes, FSM/direction enums and direction steps
// for the four-connect turn controller and its board store.
package four_connect_pkg;

  // cell / player codes
  localparam logic [1:0] P_EMPTY = 2'b00;
  localparam logic [1:0] P_ONE   = 2'b01;
  localparam logic [1:0] P_TWO   = 2'b10;

  // game status codes
  localparam logic [1:0] FS_PLAY   = 2'b00;
  localparam logic [1:0] FS_P1_WIN = 2'b01;
  localparam logic [1:0] FS_P2_WIN = 2'b10;
  localparam logic [1:0] FS_DRAW   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLACE,
    ST_SCAN,
    ST_RESP,
    ST_OVER
  } state_e;

  // scan order: horizontal, vertical, "/", "\"
  typedef enum logic [1:0] {
    DIR_HORZ,
    DIR_VERT,
    DIR_DIAG_UP,
    DIR_DIAG_DN
  } dir_e;

  // step of the + side; 2'b11 encodes -1
  typedef struct packed {
    logic [1:0] drow;
    logic [1:0] dcol;
  } step_t;

  function automatic step_t dir_step(input dir_e d);
    step_t s;
    case (d)
      DIR_HORZ:    s = '{drow: 2'b00, dcol: 2'b01};
      DIR_VERT:    s = '{drow: 2'b01, dcol: 2'b00};
      DIR_DIAG_UP: s = '{drow: 2'b01, dcol: 2'b01};
      default:     s = '{drow: 2'b01, dcol: 2'b11};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/four_connect_board.sv
// four_connect_board: ROWS x COLS array of 2-bit cells. One synchronous
// write port, combinational scan and debug read ports, synchronous clear.
// Reads outside the board return EMPTY.
module four_connect_board
  import four_connect_pkg::*;
#(
  parameter int ROWS = 6,
  parameter int COLS = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_we,
  input  logic [2:0] i_wr_row,
  input  logic [2:0] i_wr_col,
  input  logic [1:0] i_wr_data,
  input  logic [2:0] i_scan_row,
  input  logic [2:0] i_scan_col,
  output logic [1:0] o_scan_cell,
  input  logic [2:0] i_dbg_row,
  input  logic [2:0] i_dbg_col,
  output logic [1:0] o_dbg_cell
);

  localparam logic [3:0] ROWS_W = 4'(ROWS);
  localparam logic [3:0] COLS_W = 4'(COLS);

  logic [ROWS-1:0][COLS-1:0][1:0] r_cells;

  logic w_wr_inb, w_scan_inb, w_dbg_inb;

  assign w_wr_inb   = ({1'b0, i_wr_row}   < ROWS_W) && ({1'b0, i_wr_col}   < COLS_W);
  assign w_scan_inb = ({1'b0, i_scan_row} < ROWS_W) && ({1'b0, i_scan_col} < COLS_W);
  assign w_dbg_inb  = ({1'b0, i_dbg_row}  < ROWS_W) && ({1'b0, i_dbg_col}  < COLS_W);

  // cell store: clear on reset, single write per cycle
  always_ff @(posedge clk) begin
    if (rst) r_cells <= '0;
    else if (i_we && w_wr_inb) r_cells[i_wr_row][i_wr_col] <= i_wr_data;
  end

  // two independent read ports, empty outside the board
  always_comb begin
    o_scan_cell = P_EMPTY;
    o_dbg_cell  = P_EMPTY;
    if (w_scan_inb) o_scan_cell = r_cells[i_scan_row][i_scan_col];
    if (w_dbg_inb)  o_dbg_cell  = r_cells[i_dbg_row][i_dbg_col];
  end

endmodule

// File: rtl/four_connect_turn_ctrl.sv
// four_connect_turn_ctrl: turn order, column capacity, gravity placement and
// game status for a four-connect board.
// Optional macro FOUR_CONNECT_WIN_CHECK_EN: when defined, a sequential win scan
// walks up to WIN_LEN-1 neighbours per side around each new disc. When not
// defined, placement goes straight to the response and only draw is detected.
module four_connect_turn_ctrl
  import four_connect_pkg::*;
#(
  parameter int COLS    = 7,
  parameter int ROWS    = 6,
  parameter int WIN_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_valid,
  input  logic [1:0] move_player,
  input  logic [2:0] move_col,
  output logic       move_ready,
  output logic       move_done,
  output logic       move_ok,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic [1:0] turn,
  output logic [1:0] final_state,
  input  logic [2:0] dbg_row,
  input  logic [2:0] dbg_col,
  output logic [1:0] dbg_cell
);

  localparam logic [3:0] COLS_W = 4'(COLS);
  localparam logic [3:0] ROWS_H = 4'(ROWS);
  localparam logic [6:0] CELLS  = 7'(ROWS * COLS);

  state_e r_state, w_state_nxt;

  logic [1:0]            r_turn, r_final;
  logic [2:0]            r_row, r_col, r_mcol;
  logic                  r_ok;
  logic [COLS-1:0][3:0]  r_height;
  logic [6:0]            r_cnt;

  logic       w_hs, w_col_full, w_legal, w_we;
  logic [2:0] w_place_row;
  logic [2:0] w_scan_row, w_scan_col;
  logic [1:0] w_scan_cell;

  assign w_hs        = move_valid && move_ready;
  assign w_legal     = (move_player == r_turn) && ({1'b0, move_col} < COLS_W) && !w_col_full;
  assign w_place_row = r_height[r_mcol][2:0];

  // full-column test only indexes heights for in-range columns
  always_comb begin
    w_col_full = 1'b0;
    if ({1'b0, move_col} < COLS_W) w_col_full = (r_height[move_col] == ROWS_H);
  end

`ifdef FOUR_CONNECT_WIN_CHECK_EN
  localparam logic signed [4:0] ROWS_S   = 5'(ROWS);
  localparam logic signed [4:0] COLS_S   = 5'(COLS);
  localparam logic [3:0]        WIN_W    = 4'(WIN_LEN);
  localparam logic [2:0]        DIST_MAX = 3'(WIN_LEN - 1);

  dir_e       r_dir;
  logic       r_side;
  logic [2:0] r_dist;
  logic [3:0] r_count;

  step_t             w_step;
  logic signed [4:0] w_dist_s, w_off_r, w_off_c, w_nr, w_nc;
  logic              w_inb, w_match, w_side_end, w_scan_win, w_scan_last;

  // neighbour address at distance r_dist on the current side of r_dir
  always_comb begin
    w_step   = dir_step(r_dir);
    w_dist_s = $signed({2'b00, r_dist});
    w_off_r  = 5'sd0;
    w_off_c  = 5'sd0;
    if (w_step.drow == 2'b01) w_off_r = w_dist_s;
    else if (w_step.drow == 2'b11) w_off_r = -w_dist_s;
    if (w_step.dcol == 2'b01) w_off_c = w_dist_s;
    else if (w_step.dcol == 2'b11) w_off_c = -w_dist_s;
    if (r_side) begin
      w_off_r = -w_off_r;
      w_off_c = -w_off_c;
    end
    w_nr = $signed({2'b00, r_row}) + w_off_r;
    w_nc = $signed({2'b00, r_col}) + w_off_c;
  end

  assign w_scan_row  = w_nr[2:0];
  assign w_scan_col  = w_nc[2:0];
  assign w_inb       = (w_nr >= 5'sd0) && (w_nr < ROWS_S) && (w_nc >= 5'sd0) && (w_nc < COLS_S);
  assign w_match     = w_inb && (w_scan_cell == r_turn);
  assign w_side_end  = !w_match || (r_dist == DIST_MAX);
  assign w_scan_win  = (r_state == ST_SCAN) && w_match && ((r_count + 4'd1) == WIN_W);
  assign w_scan_last = (r_state == ST_SCAN) && !w_scan_win && w_side_end && r_side &&
                       (r_dir == DIR_DIAG_DN);

  // scan walker: restart at PLACE, advance distance/side/direction in SCAN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir   <= DIR_HORZ;
      r_side  <= 1'b0;
      r_dist  <= 3'd1;
      r_count <= 4'd1;
    end else if (r_state == ST_PLACE) begin
      r_dir   <= DIR_HORZ;
      r_side  <= 1'b0;
      r_dist  <= 3'd1;
      r_count <= 4'd1;
    end else if (r_state == ST_SCAN) begin
      if (!w_side_end) begin
        r_dist  <= r_dist + 3'd1;
        r_count <= r_count + 4'd1;
      end else if (!r_side) begin
        // keep the + side tally; a match at the last distance still counts
        r_side  <= 1'b1;
        r_dist  <= 3'd1;
        r_count <= r_count + {3'b000, w_match};
      end else begin
        r_side  <= 1'b0;
        r_dist  <= 3'd1;
        r_count <= 4'd1;
        r_dir   <= dir_e'(r_dir + 2'd1);
      end
    end
  end
`else
  // board scan port has no consumer in this build
  assign w_scan_row = 3'd0;
  assign w_scan_col = 3'd0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_hs) w_state_nxt = w_legal ? ST_PLACE : ST_RESP;
`ifdef FOUR_CONNECT_WIN_CHECK_EN
      ST_PLACE: w_state_nxt = ST_SCAN;
      ST_SCAN:  if (w_scan_win || w_scan_last) w_state_nxt = ST_RESP;
`else
      ST_PLACE: w_state_nxt = ST_RESP;
`endif
      ST_RESP:  w_state_nxt = (r_final != FS_PLAY) ? ST_OVER : ST_IDLE;
      ST_OVER:  w_state_nxt = ST_OVER;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    move_ready = (r_state == ST_IDLE);
    move_done  = (r_state == ST_RESP);
    w_we       = (r_state == ST_PLACE);
  end

  // move datapath: capture at handshake, place, then settle turn/status
  always_ff @(posedge clk) begin
    if (rst) begin
      r_turn   <= P_ONE;
      r_final  <= FS_PLAY;
      r_row    <= 3'd0;
      r_col    <= 3'd0;
      r_mcol   <= 3'd0;
      r_ok     <= 1'b0;
      r_height <= '0;
      r_cnt    <= 7'd0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_hs) begin
          r_ok   <= w_legal;
          r_mcol <= move_col;
        end
        ST_PLACE: begin
          r_row            <= w_place_row;
          r_col            <= r_mcol;
          r_height[r_mcol] <= r_height[r_mcol] + 4'd1;
          r_cnt            <= r_cnt + 7'd1;
`ifndef FOUR_CONNECT_WIN_CHECK_EN
          if ((r_cnt + 7'd1) == CELLS) r_final <= FS_DRAW;
          else                         r_turn  <= r_turn ^ 2'b11;
`endif
        end
`ifdef FOUR_CONNECT_WIN_CHECK_EN
        ST_SCAN: begin
          // a win found on the last cell beats a simultaneous draw
          if (w_scan_win) r_final <= r_turn;
          else if (w_scan_last) begin
            if (r_cnt == CELLS) r_final <= FS_DRAW;
            else                r_turn  <= r_turn ^ 2'b11;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign move_ok     = r_ok;
  assign row         = r_row;
  assign col         = r_col;
  assign turn        = r_turn;
  assign final_state = r_final;

  four_connect_board #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_board (
    .clk         (clk),
    .rst         (rst),
    .i_we        (w_we),
    .i_wr_row    (w_place_row),
    .i_wr_col    (r_mcol),
    .i_wr_data   (r_turn),
    .i_scan_row  (w_scan_row),
    .i_scan_col  (w_scan_col),
    .o_scan_cell (w_scan_cell),
    .i_dbg_row   (dbg_row),
    .i_dbg_col   (dbg_col),
    .o_dbg_cell  (dbg_cell)
  );

endmodule

// File: tb/tb_four_connect_turn_ctrl.sv
// tb_four_connect_turn_ctrl: scoreboard bench for four_connect_turn_ctrl.
// Expectations follow macro FOUR_CONNECT_WIN_CHECK_EN the same way the RTL does.
module tb_four_connect_turn_ctrl;

  localparam int COLS    = 7;
  localparam int ROWS    = 6;
  localparam int WIN_LEN = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       move_valid;
  logic [1:0] move_player;
  logic [2:0] move_col;
  logic       move_ready, move_done, move_ok;
  logic [2:0] row, col;
  logic [1:0] turn, final_state;
  logic [2:0] dbg_row, dbg_col;
  logic [1:0] dbg_cell;

  four_connect_turn_ctrl #(.COLS(COLS), .ROWS(ROWS), .WIN_LEN(WIN_LEN)) dut (
    .clk(clk), .rst(rst),
    .move_valid(move_valid), .move_player(move_player), .move_col(move_col),
    .move_ready(move_ready), .move_done(move_done), .move_ok(move_ok),
    .row(row), .col(col), .turn(turn), .final_state(final_state),
    .dbg_row(dbg_row), .dbg_col(dbg_col), .dbg_cell(dbg_cell)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic       ok;
    logic [2:0] row;
    logic [2:0] col;
    logic [1:0] turn;
    logic [1:0] fin;
    int         lat;
    int         t;
  } exp_t;

  exp_t q[$];

  // reference game model
  logic [1:0] mb [ROWS][COLS];
  int         mh [8];
  logic [1:0] mturn, mfinal;
  int         mcnt;

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mb[r][c] = 2'b00;
    for (int c = 0; c < 8; c++) mh[c] = 0;
    mturn  = 2'b01;
    mfinal = 2'b00;
    mcnt   = 0;
  endtask

`ifdef FOUR_CONNECT_WIN_CHECK_EN
  // cycles spent scanning around (r0,c0) and whether a line of WIN_LEN formed
  function automatic int walk(input int r0, input int c0, input logic [1:0] p, output bit win);
    int dr [4] = '{0, 1, 1, 1};
    int dc [4] = '{1, 0, 1, -1};
    int s = 0;
    int cnt, sg, rr, cc;
    win = 1'b0;
    for (int d = 0; d < 4; d++) begin
      cnt = 1;
      for (int side = 0; side < 2; side++) begin
        sg = (side == 0) ? 1 : -1;
        for (int k = 1; k < WIN_LEN; k++) begin
          s++;
          rr = r0 + sg * k * dr[d];
          cc = c0 + sg * k * dc[d];
          if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS && mb[rr][cc] == p) begin
            cnt++;
            if (cnt == WIN_LEN) begin
              win = 1'b1;
              return s;
            end
          end else break;
        end
      end
    end
    return s;
  endfunction
`endif

  // scoreboard consumer: every move_done pops one expectation
  logic rdy_chk = 1'b0;
  logic rdy_exp = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rdy_chk) begin
      chk("ready_after_done", move_ready, rdy_exp);
      rdy_chk = 1'b0;
    end
    if (move_done) begin
      if (q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("latency", cyc - e.t, e.lat);
        chk("move_ok", move_ok, e.ok);
        if (e.ok) begin
          chk("row", row, e.row);
          chk("col", col, e.col);
        end
        chk("turn", turn, e.turn);
        chk("final_state", final_state, e.fin);
        chk("ready_in_resp", move_ready, 0);
        rdy_chk = 1'b1;
        rdy_exp = (e.fin == 2'b00);
      end
    end
  end

  // drive one move at the handshake, push the model's expectation, drain
  task automatic send(input logic [1:0] p, input int c);
    exp_t e;
    int   n;
    bit   win;
    n = 0;
    while (!move_ready && n < 64) begin @(negedge clk); n++; end
    if (!move_ready) begin
      chk("ready_wait", 0, 1);
      return;
    end
    e.t = cyc; e.ok = 1'b0; e.row = 3'd0; e.col = 3'd0; e.lat = 1;
    win = 1'b0;
    if (p == mturn && c < COLS && mh[c] < ROWS) begin
      e.ok  = 1'b1;
      e.row = 3'(mh[c]);
      e.col = 3'(c);
      mb[mh[c]][c] = p;
      mh[c]++;
      mcnt++;
`ifdef FOUR_CONNECT_WIN_CHECK_EN
      e.lat = 2 + walk(e.row, c, p, win);
`else
      e.lat = 2;
`endif
      if (win)                    mfinal = p;
      else if (mcnt == ROWS*COLS) mfinal = 2'b11;
      else                        mturn  = mturn ^ 2'b11;
    end
    e.turn = mturn;
    e.fin  = mfinal;
    q.push_back(e);
    move_valid = 1'b1; move_player = p; move_col = 3'(c);
    @(negedge clk);
    move_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic do_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1; move_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
    model_clear();
  endtask

  task automatic check_board(input string tag);
    int mism = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        @(negedge clk);
        dbg_row = 3'(r); dbg_col = 3'(c);
        #1;
        if (dbg_cell !== mb[r][c]) mism++;
      end
    chk(tag, mism, 0);
  endtask

  task automatic check_reset();
    chk("rst_ready", move_ready, 1);
    chk("rst_done", move_done, 0);
    chk("rst_ok", move_ok, 0);
    chk("rst_row", row, 0);
    chk("rst_col", col, 0);
    chk("rst_turn", turn, 2'b01);
    chk("rst_final", final_state, 2'b00);
    check_board("rst_board");
  endtask

  // game over: requests must not be taken
  task automatic check_over();
    int hits = 0;
    move_valid = 1'b1; move_player = mturn; move_col = 3'd0;
    repeat (10) begin
      @(negedge clk);
      if (move_ready) hits++;
    end
    move_valid = 1'b0;
    chk("over_ready", hits, 0);
  endtask

  initial begin
    int n;
    int pa [3] = '{0, 1, 4};
    int pb [3] = '{2, 3, 6};
    rst = 1'b1; move_valid = 1'b0; move_player = 2'b00; move_col = 3'd0;
    dbg_row = 3'd0; dbg_col = 3'd0;
    model_clear();

    do_reset();
    check_reset();

    // wrong player, then column out of range
    send(2'b10, 0);
    send(2'b01, 7);
    check_board("board_after_rejects");

    // single disc on an empty board
    send(2'b01, 3);
    @(negedge clk);
    dbg_row = 3'd0; dbg_col = 3'd3; #1;
    chk("dbg_0_3", dbg_cell, 2'b01);
    check_board("board_single");

    // seven drops into one column: the last hits a full column
    do_reset();
    for (int i = 0; i < 7; i++) send((i % 2 == 0) ? 2'b01 : 2'b10, 2);
    check_board("board_col_full");

    // horizontal line for player 1 on the bottom row
    do_reset();
    for (int i = 0; i < 3; i++) begin send(2'b01, i); send(2'b10, i); end
    send(2'b01, 3);
`ifdef FOUR_CONNECT_WIN_CHECK_EN
    chk("win_final", final_state, 2'b01);
`else
    chk("win_final", final_state, 2'b00);
`endif
    if (mfinal != 2'b00) check_over();
    check_board("board_win");

    // full board without any line: columns X X Y Y X X Y
    do_reset();
    for (int k = 0; k < 3; k++)
      repeat (3) begin
        send(2'b01, pa[k]); send(2'b10, pb[k]);
        send(2'b01, pb[k]); send(2'b10, pa[k]);
      end
    repeat (3) begin send(2'b01, 5); send(2'b10, 5); end
    chk("draw_final", final_state, 2'b11);
    check_over();
    check_board("board_draw");

    // reset in the middle of the winning move
    do_reset();
    for (int i = 0; i < 3; i++) begin send(2'b01, i); send(2'b10, i); end
    n = 0;
    while (!move_ready && n < 64) begin @(negedge clk); n++; end
    chk("ready_before_abort", move_ready, 1);
    move_valid = 1'b1; move_player = 2'b01; move_col = 3'd3;
    @(negedge clk);
    move_valid = 1'b0;
`ifdef FOUR_CONNECT_WIN_CHECK_EN
    repeat (2) @(negedge clk);
`endif
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    check_reset();
    repeat (15) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation timeout");
  end

endmodule
